// File: rtl/mem_grid_pkg.sv
// Shared types and helpers for the mem_grid storage primitive.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package mem_grid_pkg;

  // Clear-engine states: idle accepts accesses, clear sweeps one row per cycle.
  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  // Address width for n entries; a single entry still gets a 1-bit address.
  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_grid_row.sv
// One row of COLS x WIDTH flops with per-column write enables and a row clear.
// Latency: write lands at the clock edge; read mux is combinational (0 cycles).
// Backpressure: none; the parent gates writes and clears, an out-of-range column reads 0.
module mem_grid_row
  import mem_grid_pkg::*;
#(
  parameter int  COLS  = 4,
  parameter int  WIDTH = 1,
  localparam int CW    = addr_w(COLS)
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic [COLS-1:0]  i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_clr,
  input  logic [CW-1:0]    i_rd_col,
  output logic [WIDTH-1:0] o_rd_data
);

  logic [WIDTH-1:0] r_cell [COLS];

  // Cell storage: clear wins over write, though the parent never drives both at once.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      for (int c = 0; c < COLS; c++) r_cell[c] <= '0;
    end else begin
      for (int c = 0; c < COLS; c++) begin
        if (i_clr)          r_cell[c] <= '0;
        else if (i_wr_en[c]) r_cell[c] <= i_wr_data;
      end
    end
  end

  // Column select; unmatched (out-of-range) column addresses fall through to 0.
  always_comb begin
    o_rd_data = '0;
    for (int c = 0; c < COLS; c++) begin
      if (i_rd_col == CW'(c)) o_rd_data = r_cell[c];
    end
  end

endmodule

// File: rtl/mem_grid.sv
// ROWS x COLS x WIDTH flop grid: one write port, registered read port, row-sweep clear.
// Latency: read data and valid 1 cycle after rd_en; clear takes exactly ROWS cycles.
// Backpressure: while o_busy is high, reads, writes and clear requests are dropped.
// Optional macro MEM_GRID_FWD_EN: same-cycle read of the cell being written returns wr_data.
module mem_grid
  import mem_grid_pkg::*;
#(
  parameter int  ROWS  = 4,
  parameter int  COLS  = 4,
  parameter int  WIDTH = 1,
  localparam int RW    = addr_w(ROWS),
  localparam int CW    = addr_w(COLS)
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_wr_en,
  input  logic [RW-1:0]    i_wr_row,
  input  logic [CW-1:0]    i_wr_col,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  input  logic [RW-1:0]    i_rd_row,
  input  logic [CW-1:0]    i_rd_col,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_rd_valid,
  input  logic             i_clr_req,
  output logic             o_busy
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [RW-1:0]    r_sweep;
  logic             w_busy;
  logic             w_wr_ok;
  logic             w_rd_ok;
  logic             w_sweep_last;
  logic [WIDTH-1:0] w_rd_cell;
  logic [WIDTH-1:0] w_rd_next;
  logic [WIDTH-1:0] w_row_rd [ROWS];

  assign w_busy       = (r_state == CLEAR);
  assign o_busy       = w_busy;
  assign w_wr_ok      = i_wr_en && !w_busy && (int'(i_wr_row) < ROWS) && (int'(i_wr_col) < COLS);
  assign w_rd_ok      = i_rd_en && !w_busy;
  assign w_sweep_last = (r_sweep == RW'(ROWS - 1));

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    logic [COLS-1:0] w_wen;
    logic            w_clr;

    // Decode the write address into a one-hot column enable for this row.
    always_comb begin
      w_wen = '0;
      for (int c = 0; c < COLS; c++) begin
        if (w_wr_ok && (i_wr_row == RW'(r)) && (i_wr_col == CW'(c))) w_wen[c] = 1'b1;
      end
    end

    assign w_clr = w_busy && (r_sweep == RW'(r));

    mem_grid_row #(
      .COLS (COLS),
      .WIDTH(WIDTH)
    ) u_row (
      .i_clock  (i_clock),
      .i_reset  (i_reset),
      .i_wr_en  (w_wen),
      .i_wr_data(i_wr_data),
      .i_clr    (w_clr),
      .i_rd_col (i_rd_col),
      .o_rd_data(w_row_rd[r])
    );
  end

  // Row select; an out-of-range row address reads as 0.
  always_comb begin
    w_rd_cell = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (i_rd_row == RW'(r)) w_rd_cell = w_row_rd[r];
    end
  end

`ifdef MEM_GRID_FWD_EN
  // An accepted write implies an in-range address, so a match here is always in range.
  assign w_rd_next = (w_wr_ok && (i_wr_row == i_rd_row) && (i_wr_col == i_rd_col))
                     ? i_wr_data : w_rd_cell;
`else
  assign w_rd_next = w_rd_cell;
`endif

  // Next-state: a clear request starts the sweep, the last row ends it.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (i_clr_req)    w_state_nxt = CLEAR;
      CLEAR:   if (w_sweep_last) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  // Sweep row counter: advances each cleared row, wraps to 0 for the next sweep.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset)     r_sweep <= '0;
    else if (w_busy) r_sweep <= w_sweep_last ? '0 : r_sweep + 1'b1;
  end

  // Read register: data holds between accepted reads, valid pulses per accepted read.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      o_rd_data  <= '0;
      o_rd_valid <= 1'b0;
    end else begin
      o_rd_valid <= w_rd_ok;
      if (w_rd_ok) o_rd_data <= w_rd_next;
    end
  end

endmodule

// File: tb/tb_mem_grid.sv
// Self-checking bench for mem_grid: a 4x4x8 and a 3x3x8 instance share one stimulus stream.
// Latency: model predicts registered outputs one edge after the sampled inputs.
// Backpressure: model drops accesses while its clear countdown is running.
module tb_mem_grid;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0, rd_en = 1'b0, clr_req = 1'b0;
  logic [1:0] wr_row = '0, wr_col = '0, rd_row = '0, rd_col = '0;
  logic [7:0] wr_data = '0;

  logic [7:0] a_rd_data, b_rd_data;
  logic       a_rd_valid, b_rd_valid, a_busy, b_busy;

  int checks   = 0;
  int failures = 0;
  bit cmp_on   = 1'b0;

  always #5 clk = ~clk;

  mem_grid #(.ROWS(4), .COLS(4), .WIDTH(8)) u_a (
    .i_clock(clk), .i_reset(rst),
    .i_wr_en(wr_en), .i_wr_row(wr_row), .i_wr_col(wr_col), .i_wr_data(wr_data),
    .i_rd_en(rd_en), .i_rd_row(rd_row), .i_rd_col(rd_col),
    .o_rd_data(a_rd_data), .o_rd_valid(a_rd_valid),
    .i_clr_req(clr_req), .o_busy(a_busy)
  );

  mem_grid #(.ROWS(3), .COLS(3), .WIDTH(8)) u_b (
    .i_clock(clk), .i_reset(rst),
    .i_wr_en(wr_en), .i_wr_row(wr_row), .i_wr_col(wr_col), .i_wr_data(wr_data),
    .i_rd_en(rd_en), .i_rd_row(rd_row), .i_rd_col(rd_col),
    .o_rd_data(b_rd_data), .o_rd_valid(b_rd_valid),
    .i_clr_req(clr_req), .o_busy(b_busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each instance: a plain 4x4 array (unused entries ignored), a countdown of clear
  // cycles still to run, and the expected registered read outputs.
  logic [7:0] mm [2][4][4];
  int         left [2];
  logic [7:0] e_data [2];
  logic       e_valid [2];
  int         zr;

  function automatic int lim(input int i);
    return (i == 0) ? 4 : 3;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 4; c++) mm[i][r][c] = 8'h00;
        left[i]    = 0;
        e_data[i]  = 8'h00;
        e_valid[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (left[i] > 0) begin
          zr = lim(i) - left[i];
          for (int c = 0; c < 4; c++) mm[i][zr][c] = 8'h00;
          left[i]    = left[i] - 1;
          e_valid[i] = 1'b0;
        end else begin
          if (rd_en) begin
            e_valid[i] = 1'b1;
            if (int'(rd_row) < lim(i) && int'(rd_col) < lim(i)) begin
              e_data[i] = mm[i][rd_row][rd_col];
`ifdef MEM_GRID_FWD_EN
              if (wr_en && wr_row == rd_row && wr_col == rd_col) e_data[i] = wr_data;
`endif
            end else begin
              e_data[i] = 8'h00;
            end
          end else begin
            e_valid[i] = 1'b0;
          end
          if (wr_en && int'(wr_row) < lim(i) && int'(wr_col) < lim(i))
            mm[i][wr_row][wr_col] = wr_data;
          if (clr_req) left[i] = lim(i);
        end
      end
    end
  end

  // Compare both instances against the model on every falling edge out of reset.
  always @(negedge clk) begin
    if (!rst && cmp_on) begin
      chk("a_rd_data",  a_rd_data,  e_data[0]);
      chk("a_rd_valid", a_rd_valid, e_valid[0]);
      chk("a_busy",     a_busy,     left[0] != 0);
      chk("b_rd_data",  b_rd_data,  e_data[1]);
      chk("b_rd_valid", b_rd_valid, e_valid[1]);
      chk("b_busy",     b_busy,     left[1] != 0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input bit we, input int wr, input int wc, input logic [7:0] wd,
                     input bit re, input int rr, input int rc, input bit clr);
    logic [31:0] t;
    wr_en = we; rd_en = re; clr_req = clr; wr_data = wd;
    t = wr; wr_row = t[1:0];
    t = wc; wr_col = t[1:0];
    t = rr; rd_row = t[1:0];
    t = rc; rd_col = t[1:0];
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(0, 0, 0, 8'h00, 0, 0, 0, 0);
  endtask

  task automatic wrc(input int r, input int c, input logic [7:0] d);
    cyc(1, r, c, d, 0, 0, 0, 0);
  endtask

  task automatic rdc(input int r, input int c);
    cyc(0, 0, 0, 8'h00, 1, r, c, 0);
  endtask

  int n;

  initial begin
    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_a_data",  a_rd_data,  0);
    chk("rst_a_valid", a_rd_valid, 0);
    chk("rst_a_busy",  a_busy,     0);
    rst    = 1'b0;
    cmp_on = 1'b1;

    // Every cell reads 0 after reset, back-to-back reads keep valid high.
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        rdc(r, c);
        chk("rst_read_valid", a_rd_valid, 1);
        chk("rst_read_data",  a_rd_data,  0);
      end

    // Write then read next cycle; neighbour still 0.
    wrc(2, 3, 8'hA5);
    rdc(2, 3);
    chk("wr_rd_data",  a_rd_data,  8'hA5);
    chk("wr_rd_valid", a_rd_valid, 1);
    rdc(2, 2);
    chk("neighbour_zero", a_rd_data, 8'h00);
    idle();
    chk("valid_drops", a_rd_valid, 0);
    chk("data_holds",  a_rd_data,  8'h00);

    // Same-cycle read and write of one cell.
    wrc(1, 1, 8'h11);
    cyc(1, 1, 1, 8'h22, 1, 1, 1, 0);
`ifdef MEM_GRID_FWD_EN
    chk("collision", a_rd_data, 8'h22);
`else
    chk("collision", a_rd_data, 8'h11);
`endif
    rdc(1, 1);
    chk("collision_after", a_rd_data, 8'h22);

    // Fill, clear, write during busy is dropped, all cells read 0.
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) wrc(r, c, 8'(r * 16 + c + 1));
    cyc(0, 0, 0, 8'h00, 0, 0, 0, 1);
    n = 0;
    while (a_busy && n < 10) begin
      n++;
      wrc(1, 1, 8'hEE);
    end
    chk("clr_busy_cycles", n, 4);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        rdc(r, c);
        chk("clr_read_zero", a_rd_data, 8'h00);
      end

    // Clear request together with a write: the write lands, then gets swept.
    cyc(1, 0, 0, 8'h7F, 0, 0, 0, 1);
    repeat (4) idle();
    rdc(0, 0);
    chk("clr_wr_valid", a_rd_valid, 1);
    chk("clr_wr_data",  a_rd_data,  8'h00);

    // Reset two cycles into a sweep; the read issued with the clear loads 5A first.
    wrc(1, 2, 8'h5A);
    cyc(0, 0, 0, 8'h00, 1, 1, 2, 1);
    chk("clr_rd_same_edge", a_rd_data, 8'h5A);
    idle();
    idle();
    #2 rst = 1'b1;
    #1;
    chk("midrst_a_busy",  a_busy,     0);
    chk("midrst_b_busy",  b_busy,     0);
    chk("midrst_a_valid", a_rd_valid, 0);
    chk("midrst_a_data",  a_rd_data,  0);
    @(negedge clk);
    rst = 1'b0;
    rdc(1, 2);
    chk("midrst_read_zero", a_rd_data, 8'h00);

    // Out-of-range on the 3x3 instance (row 3 exists only in the 4x4 one).
    wrc(0, 0, 8'h33);
    wrc(3, 0, 8'h55);
    rdc(3, 0);
    chk("oor_b_valid", b_rd_valid, 1);
    chk("oor_b_data",  b_rd_data,  8'h00);
    chk("oor_a_data",  a_rd_data,  8'h55);
    rdc(0, 0);
    chk("oor_b_row0", b_rd_data, 8'h33);

    // Randomized traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      cyc($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 3),
          8'($urandom_range(0, 255)), $urandom_range(0, 1),
          $urandom_range(0, 3), $urandom_range(0, 3), ($urandom_range(0, 39) == 0));
    end
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_grid.md
# mem_grid

Parametrised ROWS x COLS flip-flop memory grid with one synchronous write port, one registered read port and a hardware row-sweep clear engine. It supersedes the fixed 4x4 single-bit row/column select array. Cell width is configurable, and the block adds read-valid signalling and a busy-flagged bulk clear. It is the general-purpose small storage primitive for control and lookup state throughout the design.

## Interface
- ROWS, default 4: number of rows, 1 or greater.
- COLS, default 4: number of columns, 1 or greater.
- WIDTH, default 1: bits per cell.
- RW, derived: (ROWS>1) ? $clog2(ROWS) : 1. Row address width.
- CW, derived: (COLS>1) ? $clog2(COLS) : 1. Column address width.

Ports:
- clock  in  1  single clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high.
- wr_en  in  1  write strobe.
- wr_row  in  RW  write row address.
- wr_col  in  CW  write column address.
- wr_data  in  WIDTH  write data.
- rd_en  in  1  read strobe.
- rd_row  in  RW  read row address.
- rd_col  in  CW  read column address.
- rd_data  out  WIDTH  registered read data.
- rd_valid  out  1  one-cycle pulse, rd_data updated.
- clr_req  in  1  request a clear of the whole array.
- busy  out  1  clear sweep in progress.

## Operation
- Reset, asynchronous: every cell = 0, rd_data = 0, rd_valid = 0, busy = 0, FSM = IDLE, sweep counter = 0. Reset asserted mid-sweep aborts the sweep immediately with the same values.
- FSM has two states:
  - IDLE -> CLEAR on clr_req.
  - CLEAR -> IDLE when the sweep counter = ROWS-1.
  - busy = (state == CLEAR).
- Write: accepted when wr_en=1 and busy=0. The cell is updated at the edge.
  - An out-of-range address (wr_row >= ROWS or wr_col >= COLS) is silently dropped.
- Read: accepted when rd_en=1 and busy=0.
  - rd_data is loaded at the edge and rd_valid=1 for the next cycle.
  - rd_data holds its value until the next accepted read.
  - An out-of-range read returns 0 with rd_valid=1.
- Read and write to the same cell in the same cycle: rd_data gets the old contents (see Configuration for the alternative).
- Clear sweep: in CLEAR, one row is zeroed per cycle, row index = sweep counter, counting 0..ROWS-1.
- While busy=1:
  - wr_en and rd_en are ignored and rd_valid stays 0.
  - clr_req is ignored.
- clr_req together with wr_en and/or rd_en in IDLE: the write and the read are both performed at that edge, then the sweep starts. The written cell is therefore cleared later.

## Timing
- Write-to-read latency: 1. A read issued in the cycle after a write sees the new data.
- Read latency: 1. rd_en is sampled at edge N; rd_data and rd_valid are valid after edge N.
- Clear timing, with clr_req sampled at edge N:
  - busy=1 from after edge N until after edge N+ROWS.
  - Row k is zeroed at edge N+1+k.
  - The first new access is accepted at edge N+ROWS+1.
- Clear duration is exactly ROWS cycles, independent of COLS.
- Back-to-back reads: one per cycle, and rd_valid stays high continuously.

## Configuration
- MEM_GRID_FWD_EN: write-to-read forwarding.
  - Defined: a same-cycle read and write to the same in-range cell returns wr_data on rd_data.
  - Undefined: the read returns the old contents.
- All other behaviour is identical with or without the macro.

## Structure
- Package mem_grid_pkg holds:
  - the FSM state typedef (IDLE, CLEAR);
  - the address-width helper function (RW/CW rule above).
- Sub-module mem_grid_row holds one row of COLS x WIDTH flops and provides:
  - per-column write enable;
  - a row clear input;
  - asynchronous reset;
  - a combinational column-mux read output.
- mem_grid instantiates ROWS copies of mem_grid_row via generate, plus the FSM, the sweep counter and the read register.

## Test plan
- Reset check: hold reset, release it, then read all 16 cells (ROWS=COLS=4, WIDTH=8) -> each read returns 0 with rd_valid=1 one cycle after rd_en.
- Write then read: write 0xA5 to (2,3), then read (2,3) in the next cycle -> rd_data=0xA5 and rd_valid=1 one cycle later; (2,2) still reads 0.
- Same-cycle collision: the cell holds 0x11; write 0x22 and read the same cell together.
  - Without the macro -> rd_data=0x11.
  - With MEM_GRID_FWD_EN -> rd_data=0x22.
- Clear sweep: fill all cells, then pulse clr_req at edge N -> busy high for exactly 4 cycles; a write during busy is dropped; every cell reads 0 afterward.
- Simultaneous clr_req and wr_en in IDLE: write 0x7F to (0,0) -> the cell reads 0 after the sweep.
- Reset during the sweep: assert reset 2 cycles into a clear -> busy=0 and rd_valid=0 immediately; the array reads all 0 after reset release.
- Out-of-range access (ROWS=3): write to row 3 -> dropped, rows 0-2 unchanged; read of row 3 -> rd_data=0 with rd_valid=1.
